// File: rtl/seq_sorter_id.sv
// Sequential batch sorter: loads N values, sorts them with an odd-even transposition
// network (one phase per cycle), then streams them out tagged with their arrival index.
module seq_sorter_id #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             desc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [ID_W-1:0]  out_id,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        OUT
    } state_t;

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N - 1);

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] slot      [N];
    logic [ID_W-1:0]  id        [N];
    logic [WIDTH-1:0] sort_slot [N];
    logic [ID_W-1:0]  sort_id   [N];

    // cnt is the load index in LOAD, the phase number in SORT and the read pointer in OUT
    logic [ID_W-1:0] cnt;
    logic            desc_q;
    logic            accept;
    logic            cnt_at_last;

    assign accept      = in_valid && in_ready;
    assign cnt_at_last = (cnt == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b0;
        out_data   = slot[cnt];
        out_id     = id[cnt];
        case (state)
            LOAD: begin
                in_ready = !rst;
                if (accept && cnt_at_last) begin
                    next_state = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                if (cnt_at_last) begin
                    next_state = OUT;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = cnt_at_last;
                if (out_ready && cnt_at_last) begin
                    next_state = LOAD;
                end
            end
            default: begin
                next_state = LOAD;
            end
        endcase
    end

    // One transposition phase: even phases pair (0,1),(2,3)..; odd phases pair (1,2),(3,4)..
    // Strict compare keeps equal values in arrival order.
    always_comb begin
        sort_slot = slot;
        sort_id   = id;
        for (int i = 0; i < N - 1; i++) begin
            if (i[0] == cnt[0]) begin
                if (desc_q ? (slot[i] < slot[i+1]) : (slot[i] > slot[i+1])) begin
                    sort_slot[i]   = slot[i+1];
                    sort_slot[i+1] = slot[i];
                    sort_id[i]     = id[i+1];
                    sort_id[i+1]   = id[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                slot[i] <= '0;
                id[i]   <= '0;
            end
            cnt    <= '0;
            desc_q <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        slot[cnt] <= in_data;
                        id[cnt]   <= cnt;
                        if (cnt == '0) begin
                            desc_q <= desc;
                        end
                        cnt <= cnt_at_last ? '0 : cnt + ID_W'(1);
                    end
                end
                SORT: begin
                    slot <= sort_slot;
                    id   <= sort_id;
                    cnt  <= cnt_at_last ? '0 : cnt + ID_W'(1);
                end
                OUT: begin
                    if (out_ready) begin
                        cnt <= cnt_at_last ? '0 : cnt + ID_W'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sorter_id.sv
// Directed bench for seq_sorter_id: a 4x4-bit instance for ordering, stability, backpressure
// and reset cases, and an 8x8-bit instance for back-to-back batches.
module tb_seq_sorter_id;

    logic clk;
    logic rst;

    logic       in_valid4, in_ready4, desc4, out_valid4, out_ready4, out_last4, busy4;
    logic [3:0] in_data4, out_data4;
    logic [1:0] out_id4;

    logic       in_valid8, in_ready8, desc8, out_valid8, out_ready8, out_last8, busy8;
    logic [7:0] in_data8, out_data8;
    logic [2:0] out_id8;

    int check_count;
    int fail_count;

    seq_sorter_id #(.WIDTH(4), .N(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .desc(desc4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_id(out_id4), .out_last(out_last4), .busy(busy4)
    );

    seq_sorter_id #(.WIDTH(8), .N(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .desc(desc8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_id(out_id8), .out_last(out_last8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Loads one batch into the 4-wide instance; returns at the negedge after the last accept
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                                 input logic [3:0] d, input logic desc_first, input logic desc_rest);
        logic [3:0] v [4];
        int guard;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            in_valid4 = 1'b1;
            in_data4  = v[i];
            desc4     = (i == 0) ? desc_first : desc_rest;
            guard     = 0;
            while (!in_ready4 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard == 50) begin
                checkOutput("load_timeout", 32'd0, 32'd1);
            end
            @(negedge clk);
        end
        in_valid4 = 1'b0;
    endtask

    // Drains one batch with out_ready held high; element 0 sits in the top nibble/pair
    task automatic drainBatch4(input string tag, input logic [15:0] exp_data, input logic [7:0] exp_id);
        int guard;
        out_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            guard = 0;
            while (!out_valid4 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            checkOutput($sformatf("%s_valid%0d", tag, i), 32'(out_valid4), 32'd1);
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(out_data4), 32'(exp_data[15-4*i -: 4]));
            checkOutput($sformatf("%s_id%0d", tag, i), 32'(out_id4), 32'(exp_id[7-2*i -: 2]));
            checkOutput($sformatf("%s_last%0d", tag, i), 32'(out_last4), (i == 3) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        checkOutput($sformatf("%s_done_valid", tag), 32'(out_valid4), 32'd0);
        checkOutput($sformatf("%s_done_ready", tag), 32'(in_ready4), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int hs;
        int idx;
        int guard;
        logic done;
        logic [3:0] exp_d [4];
        logic [1:0] exp_i [4];

        check_count = 0;
        fail_count  = 0;
        rst = 1'b1;
        in_valid4 = 1'b0; in_data4 = '0; desc4 = 1'b0; out_ready4 = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; desc8 = 1'b0; out_ready8 = 1'b1;

        // Reset state
        #1;
        checkOutput("rst_in_ready4", 32'(in_ready4), 32'd0);
        checkOutput("rst_out_valid4", 32'(out_valid4), 32'd0);
        checkOutput("rst_out_last4", 32'(out_last4), 32'd0);
        checkOutput("rst_busy4", 32'(busy4), 32'd0);
        checkOutput("rst_out_data4", 32'(out_data4), 32'd0);
        checkOutput("rst_out_id4", 32'(out_id4), 32'd0);
        checkOutput("rst_in_ready8", 32'(in_ready8), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready4", 32'(in_ready4), 32'd1);
        checkOutput("post_rst_in_ready8", 32'(in_ready8), 32'd1);

        // 1: basic ascending sort and latency
        applyStimulus(4'd9, 4'd3, 4'd7, 4'd1, 1'b0, 1'b0);
        checkOutput("t1_sort_busy", 32'(busy4), 32'd1);
        checkOutput("t1_sort_in_ready", 32'(in_ready4), 32'd0);
        lat = 0;
        while (!out_valid4 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("t1_latency", 32'(lat + 1), 32'd5);
        drainBatch4("t1", {4'd1, 4'd3, 4'd7, 4'd9}, {2'd3, 2'd1, 2'd2, 2'd0});

        // 2: stability with equal keys
        applyStimulus(4'd5, 4'd2, 4'd5, 4'd2, 1'b0, 1'b0);
        drainBatch4("t2", {4'd2, 4'd2, 4'd5, 4'd5}, {2'd1, 2'd3, 2'd0, 2'd2});

        // 3: descending latched from the first element only
        applyStimulus(4'd0, 4'd15, 4'd8, 4'd8, 1'b1, 1'b0);
        drainBatch4("t3", {4'd15, 4'd8, 4'd8, 4'd0}, {2'd1, 2'd2, 2'd3, 2'd0});

        // 4: backpressure, with stray input pulses while busy
        exp_d[0] = 4'd2;  exp_i[0] = 2'd2;
        exp_d[1] = 4'd6;  exp_i[1] = 2'd0;
        exp_d[2] = 4'd10; exp_i[2] = 2'd3;
        exp_d[3] = 4'd12; exp_i[3] = 2'd1;
        out_ready4 = 1'b0;
        applyStimulus(4'd6, 4'd12, 4'd2, 4'd10, 1'b0, 1'b0);
        in_valid4 = 1'b1;
        in_data4  = 4'hF;
        guard = 0;
        while (!out_valid4 && guard < 50) begin
            checkOutput("t4_sort_in_ready", 32'(in_ready4), 32'd0);
            @(negedge clk);
            guard++;
        end
        for (int s = 0; s < 7; s++) begin
            checkOutput($sformatf("t4_stall_valid%0d", s), 32'(out_valid4), 32'd1);
            checkOutput($sformatf("t4_stall_data%0d", s), 32'(out_data4), 32'(exp_d[0]));
            checkOutput($sformatf("t4_stall_id%0d", s), 32'(out_id4), 32'(exp_i[0]));
            checkOutput($sformatf("t4_stall_in_ready%0d", s), 32'(in_ready4), 32'd0);
            @(negedge clk);
        end
        hs = 0;
        idx = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done && idx < 4; c++) begin
            out_ready4 = ~out_ready4;
            checkOutput($sformatf("t4_out_in_ready_c%0d", c), 32'(in_ready4), 32'd0);
            checkOutput($sformatf("t4_data_c%0d", c), 32'(out_data4), 32'(exp_d[idx]));
            checkOutput($sformatf("t4_id_c%0d", c), 32'(out_id4), 32'(exp_i[idx]));
            if (out_valid4 && out_ready4) begin
                checkOutput($sformatf("t4_last_c%0d", c), 32'(out_last4), (idx == 3) ? 32'd1 : 32'd0);
                hs++;
                if (out_last4) begin
                    in_valid4 = 1'b0;
                    done = 1'b1;
                end
                idx++;
            end
            @(negedge clk);
        end
        in_valid4 = 1'b0;
        checkOutput("t4_handshakes", 32'(hs), 32'd4);
        checkOutput("t4_after_in_ready", 32'(in_ready4), 32'd1);
        for (int s = 0; s < 3; s++) begin
            checkOutput($sformatf("t4_after_valid%0d", s), 32'(out_valid4), 32'd0);
            @(negedge clk);
        end
        out_ready4 = 1'b1;

        // 5: asynchronous reset during sort phase 2
        applyStimulus(4'd3, 4'd2, 4'd1, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_busy_before", 32'(busy4), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_busy", 32'(busy4), 32'd0);
        checkOutput("t5_rst_out_valid", 32'(out_valid4), 32'd0);
        checkOutput("t5_rst_in_ready", 32'(in_ready4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_in_ready_after", 32'(in_ready4), 32'd1);
        checkOutput("t5_out_valid_after", 32'(out_valid4), 32'd0);
        applyStimulus(4'd4, 4'd4, 4'd0, 4'd1, 1'b0, 1'b0);
        drainBatch4("t5", {4'd0, 4'd1, 4'd4, 4'd4}, {2'd2, 2'd3, 2'd0, 2'd1});

        // 6: back-to-back batches on the 8-wide instance
        fork
            begin : producer
                int g;
                for (int i = 0; i < 16; i++) begin
                    in_valid8 = 1'b1;
                    in_data8  = (i < 8) ? 8'(i) : 8'(255 - (i - 8));
                    g = 0;
                    while (!in_ready8 && g < 100) begin
                        @(negedge clk);
                        g++;
                    end
                    if (g == 100) begin
                        checkOutput("t6_load_timeout", 32'd0, 32'd1);
                    end
                    @(negedge clk);
                end
                in_valid8 = 1'b0;
            end
            begin : consumer
                int g;
                for (int j = 0; j < 16; j++) begin
                    g = 0;
                    while (!out_valid8 && g < 100) begin
                        @(negedge clk);
                        g++;
                    end
                    checkOutput($sformatf("t6_valid%0d", j), 32'(out_valid8), 32'd1);
                    checkOutput($sformatf("t6_data%0d", j), 32'(out_data8),
                                (j < 8) ? 32'(j) : 32'(248 + (j - 8)));
                    checkOutput($sformatf("t6_id%0d", j), 32'(out_id8),
                                (j < 8) ? 32'(j) : 32'(7 - (j - 8)));
                    checkOutput($sformatf("t6_last%0d", j), 32'(out_last8),
                                ((j % 8) == 7) ? 32'd1 : 32'd0);
                    @(negedge clk);
                end
            end
        join
        for (int s = 0; s < 4; s++) begin
            checkOutput($sformatf("t6_no_extra%0d", s), 32'(out_valid8), 32'd0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/seq_sorter_id.md
Name: seq_sorter_id

Overview:
Parametrised, sequential sorter with origin tracking. It collects a batch of N values over a valid/ready input stream and sorts them in place with an odd-even transposition network, one phase per cycle. It then streams the batch out over a valid/ready output stream. Each output value is tagged with the arrival index it had in the batch. The block replaces fixed 4-input combinational sort-with-id logic where a wider, deeper, back-pressured datapath is needed.

Parameters:
- WIDTH, 4: bit width of each data value, unsigned.
- N, 4: values per batch; legal range N >= 2, not restricted to powers of two.
- ID_W, $clog2(N): width of the id tag. Derived localparam; never overridden.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: in_data is valid this cycle.
- in_ready, output, 1: block accepts input this cycle.
- in_data, input, WIDTH: value to load.
- desc, input, 1: sort order; 0 = ascending, 1 = descending. Sampled only with the first accepted element of a batch.
- out_valid, output, 1: out_data and out_id are valid.
- out_ready, input, 1: downstream accepts the output this cycle.
- out_data, output, WIDTH: sorted value.
- out_id, output, ID_W: arrival index (0..N-1) of out_data within its batch.
- out_last, output, 1: high with the final element of a batch.
- busy, output, 1: high in SORT or OUT.

Behaviour:
- State machine states: LOAD, SORT, OUT. Reset state is LOAD.
- Reset values:
  - Storage slots, id tags, counters and latched desc all clear to 0.
  - out_valid = 0, out_last = 0, busy = 0.
  - in_ready = 0 while rst is high.
- Reset mid-operation: rst aborts any state immediately and discards the partial or complete batch. No output handshake is issued for discarded data.
- LOAD:
  - in_ready = 1; out_valid = 0.
  - An input is accepted when in_valid && in_ready. On accept: slot[cnt] <= in_data, id[cnt] <= cnt, cnt increments.
  - desc is latched on the accept where cnt == 0.
  - On the accept where cnt == N-1: go to SORT, cnt <= 0.
- SORT:
  - in_ready = 0; out_valid = 0; runs exactly N cycles, one phase per cycle.
  - Phase k even: compare pairs (0,1), (2,3), ...
  - Phase k odd: compare pairs (1,2), (3,4), ...
  - For an odd N, the unpaired end slot is untouched in that phase.
  - Swap rule: ascending swaps when slot[lo] > slot[hi]; descending swaps when slot[lo] < slot[hi]. The comparison is strict, so equal values never swap and the sort is stable: equal values leave in arrival order.
  - id tags move with their values.
  - After phase N-1, go to OUT with the read pointer at 0.
- OUT:
  - out_valid = 1; out_data = slot[ptr]; out_id = id[ptr]; out_last = (ptr == N-1).
  - ptr advances only on out_valid && out_ready.
  - While out_ready = 0, outputs hold stable for any number of cycles.
  - On the handshake with out_last high: go to LOAD; in_ready rises the next cycle.
  - in_valid is ignored outside LOAD.
- Latency: if the last input is accepted on cycle t, out_valid first rises on cycle t+N+1. With no backpressure, the final output completes on cycle t+2N.
- Throughput: one batch per 3N cycles minimum.
- Width rules: unsigned comparisons only; no arithmetic; widths never extend or truncate.

Test Plan:
1. N=4, WIDTH=4, desc=0, inputs 9,3,7,1 with out_ready=1 -> (data,id) = (1,3), (3,1), (7,2), (9,0). out_last on the 4th output only. out_valid rises exactly 5 cycles after the last input accept.
2. Stability, desc=0, inputs 5,2,5,2 -> (2,1), (2,3), (5,0), (5,2).
3. desc=1 on the first element (then toggled to 0 for the rest), inputs 0,15,8,8 -> (15,1), (8,2), (8,3), (0,0). Checks that desc is latched, not live.
4. Backpressure: out_ready held low for 7 cycles, then toggled every cycle. Required: outputs stay stable while stalled, exactly 4 handshakes occur, and in_ready = 0 through SORT and OUT. in_valid pulses during SORT/OUT have no effect on results.
5. Reset asserted asynchronously mid-SORT (phase 2) -> out_valid and busy drop immediately. After rst deasserts, in_ready = 1 on the next cycle, and the following batch 4,4,0,1 gives (0,2), (1,3), (4,0), (4,1).
6. N=8, WIDTH=8: back-to-back batches, first already sorted 0..7, then reverse 255..248 (desc=0). Required: ids 0..7 for the first batch and ids 7..0 for the second. No lost or duplicated element across the batch boundary.
